product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4-bit combinational multiplier's 8-bit Product.
- Accumulates a fixed-length run of COUNT products (a dot product) into a saturating accumulator.
- Presents the total on a valid/ready output port.
- Input side uses valid/ready so a sequencer feeding the multiplier operands can be throttled.

Parameters:
- PROD_WIDTH, 8, width of incoming Product (matches the 4x4 multiplier output).
- COUNT, 4, number of products summed per result; legal range 2..256.
- ACC_WIDTH, 10, accumulator/Sum width; legal range PROD_WIDTH..PROD_WIDTH+8; the default is wide enough that 4 products never saturate.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Clear  input  1  synchronous abort; discards the partial sum.
- In_Valid  input  1  Product is valid this cycle.
- In_Ready  output  1  block accepts Product this cycle.
- Product  input  PROD_WIDTH  unsigned product from the multiplier.
- Out_Valid  output  1  Sum/Overflow are valid.
- Out_Ready  input  1  downstream accepts Sum this cycle.
- Sum  output  ACC_WIDTH  unsigned accumulated total, saturated.
- Overflow  output  1  saturation occurred in this run; valid with Out_Valid.

Behaviour:
- Reset (async, active-high): state=ACCUM, acc=0, count=0, Sum=0, Overflow=0, Out_Valid=0, In_Ready=1 (In_Ready=1 is the value after release).
- States:
  - ACCUM: In_Ready=1, Out_Valid=0.
  - DONE: In_Ready=0, Out_Valid=1.
- Accept = In_Valid & In_Ready.
- ACCUM, on accept:
  - acc <= sat(acc + zero-extended Product).
  - count++.
  - If count == COUNT-1: go to DONE, latch Sum <= sat result, Overflow <= (run's sticky flag | this add's saturation), and reset count and acc to 0.
- ACCUM with no accept: hold all registers. Bubbles on In_Valid are allowed anywhere in a run.
- Saturation:
  - If the true sum exceeds 2^ACC_WIDTH-1, acc clamps to 2^ACC_WIDTH-1.
  - A sticky internal flag is set.
  - Further adds in the run keep the clamped value.
- Latency: Out_Valid rises the cycle after the COUNT-th accept.
- DONE:
  - Sum and Overflow held stable while Out_Valid=1 & Out_Ready=0.
  - In_Valid is ignored; no product is lost because In_Ready=0.
  - On Out_Ready=1: go to ACCUM next cycle and clear the sticky flag. Sum keeps its last value but is meaningless once Out_Valid=0.
  - Minimum DONE residency is 1 cycle, so peak throughput is one result per COUNT+1 cycles.
- Clear (sync):
  - Highest priority after Reset, in any state.
  - Next cycle: state=ACCUM, acc=0, count=0, sticky=0, Out_Valid=0, Overflow=0.
  - A product presented with Clear is discarded, even though In_Ready=1.
  - A result pending in DONE is dropped.
- Reset asserted mid-run: immediate (asynchronous) return to reset values; the partial sum is lost.
- Product bits above the multiplier's range are not checked; arithmetic is purely unsigned.

Decomposition:
- Package product_accumulator_pkg holds:
  - State enum {ACCUM, DONE}, 1-bit encoding.
  - Localparam CNT_WIDTH = clog2(COUNT).
  - Function sat_add(acc, prod) returning the clamped value and a saturate bit.
- No sub-module. FSM, counter and saturating add fit in one module.
- The multiplier stays a separate instance; it is connected at the top level only.

Test Plan:
- Four accepts of Product=210 (A=15, B=14) with Out_Ready=1 -> Out_Valid one cycle after the 4th accept; Sum=840 (0x348), Overflow=0; In_Ready=0 for exactly that cycle.
- Products 225, 0, 1, 210 with In_Valid bubbles of 3 cycles between each -> Sum=436, Overflow=0; count unaffected by bubbles.
- Complete a run with Out_Ready=0 for 5 cycles while In_Valid=1, Product=99 -> Sum held at the run's value; In_Ready=0 throughout; after Out_Ready=1 the next run starts from 0 and the 99s are not summed during DONE.
- ACC_WIDTH=9 override, four products of 225 -> clamp after the 3rd add (675>511); Sum=511, Overflow=1; next run of 1, 1, 1, 1 gives Sum=4, Overflow=0.
- Two accepts (50, 60), then Clear with In_Valid=1, Product=70, then four products of 10 -> 70 discarded; Sum=40.
- Reset pulsed asynchronously mid-run (between clock edges) after 3 accepts -> outputs at reset values immediately; next four products of 5 give Sum=20.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and the saturating-add helper for the product accumulator.
// The counter is sized for the largest legal run length.
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int MAX_COUNT = 256;
  localparam int CNT_WIDTH = $clog2(MAX_COUNT);
  localparam int SAT_WIDTH = 32;

  typedef struct packed {
    logic                 sat;
    logic [SAT_WIDTH-1:0] value;
  } sat_t;

  // Unsigned add clamped to 2^acc_width-1; sat flags that the clamp engaged.
  function automatic sat_t sat_add(input logic [SAT_WIDTH-1:0] acc,
                                   input logic [SAT_WIDTH-1:0] prod,
                                   input int                   acc_width);
    logic [SAT_WIDTH:0] total;
    logic [SAT_WIDTH:0] limit;
    sat_t               r;
    total = {1'b0, acc} + {1'b0, prod};
    limit = ((SAT_WIDTH+1)'(1) << acc_width) - (SAT_WIDTH+1)'(1);
    if (total > limit) begin
      r.sat   = 1'b1;
      r.value = limit[SAT_WIDTH-1:0];
    end else begin
      r.sat   = 1'b0;
      r.value = total[SAT_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a fixed-length run of multiplier products into a saturating accumulator
// and hands the total downstream over a valid/ready port.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_WIDTH = 8,
  parameter int COUNT      = 4,
  parameter int ACC_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(COUNT - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [CNT_WIDTH-1:0]   count_reg;
  logic                   sticky_reg;
  logic [ACC_WIDTH-1:0]   sum_reg;
  logic                   overflow_reg;

  sat_t                   add_res;
  logic [ACC_WIDTH-1:0]   add_value;
  logic                   unused_add_hi;
  logic                   accept;
  logic                   last_accept;

  assign add_res       = sat_add(SAT_WIDTH'(acc_reg), SAT_WIDTH'(product), ACC_WIDTH);
  assign add_value     = add_res.value[ACC_WIDTH-1:0];
  assign unused_add_hi = ^add_res.value[SAT_WIDTH-1:ACC_WIDTH];

  // A product presented alongside clear is dropped even though in_ready is high.
  assign accept      = in_valid & in_ready & ~clear;
  assign last_accept = accept & (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ACCUM;
    end else begin
      case (state_reg)
        ACCUM:   if (last_accept) state_next = DONE;
        DONE:    if (out_ready)   state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_reg == ACCUM);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      sticky_reg   <= 1'b0;
      sum_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      sticky_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      if (last_accept) begin
        sum_reg      <= add_value;
        overflow_reg <= sticky_reg | add_res.sat;
        acc_reg      <= '0;
        count_reg    <= '0;
      end else begin
        acc_reg    <= add_value;
        count_reg  <= count_reg + 1'b1;
        sticky_reg <= sticky_reg | add_res.sat;
      end
    end else if (out_valid && out_ready) begin
      sticky_reg <= 1'b0;
    end
  end

  assign sum      = sum_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 10-bit and a 9-bit accumulator share stimulus; expected
// totals are queued when a run is driven and compared when the result appears.
module tb_product_accumulator;

  typedef struct packed {
    logic [9:0] s10;
    logic       o10;
    logic [8:0] s9;
    logic       o9;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] product = 8'd0;

  logic       in_ready, out_valid, overflow;
  logic [9:0] sum;
  logic       in_ready9, out_valid9, overflow9;
  logic [8:0] sum9;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow)
  );

  product_accumulator #(.PROD_WIDTH(8), .COUNT(4), .ACC_WIDTH(9)) dut9 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready9),
    .product(product), .out_valid(out_valid9), .out_ready(out_ready),
    .sum(sum9), .overflow(overflow9)
  );

  function automatic res_t model(input int unsigned total);
    res_t r;
    r.s10 = (total > 1023) ? 10'd1023 : 10'(total);
    r.o10 = (total > 1023);
    r.s9  = (total > 511) ? 9'd511 : 9'(total);
    r.o9  = (total > 511);
    return r;
  endfunction

  // Presents one product and returns at the falling edge after it is accepted.
  task automatic push_product(input int unsigned p);
    int guard = 0;
    product  = 8'(p);
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_run(input int unsigned p0, input int unsigned p1,
                          input int unsigned p2, input int unsigned p3,
                          input int bubbles, input bit push_exp);
    int unsigned p[4];
    int unsigned total;
    p = '{p0, p1, p2, p3};
    total = p0 + p1 + p2 + p3;
    if (push_exp) exp_q.push_back(model(total));
    for (int i = 0; i < 4; i++) begin
      push_product(p[i]);
      if (i < 3) repeat (bubbles) @(negedge clk);
    end
  endtask

  // Waits for out_valid, captures both results, and steps past the handshake.
  task automatic get_result(output res_t act);
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
      act = 'x;
    end else begin
      act = {sum, overflow, sum9, overflow9};
      $display("result: sum10=%0d ovf10=%b sum9=%0d ovf9=%b", sum, overflow, sum9, overflow9);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, sum, overflow} !== {1'b0, 1'b1, 10'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold: ov=%b ir=%b sum=%0d ovf=%b required 0 1 0 0",
               out_valid, in_ready, sum, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, sum, overflow} !== {1'b0, 1'b1, 10'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: ov=%b ir=%b sum=%0d ovf=%b required 0 1 0 0",
               out_valid, in_ready, sum, overflow);
    end
  endtask

  task automatic test_basic();
    res_t act, e;
    out_ready = 1'b1;
    send_run(210, 210, 210, 210, 0, 1'b1);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL basic_result: got %h required %h", act, e);
    end
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_done_one_cycle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_bubbles();
    res_t act, e;
    send_run(225, 0, 1, 210, 3, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL bubbles_result: got %h required %h", act, e);
    end
  endtask

  task automatic test_backpressure();
    res_t act, e;
    out_ready = 1'b0;
    send_run(7, 8, 9, 10, 0, 1'b1);
    in_valid = 1'b1;
    product  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 10'd34}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: ov=%b ir=%b sum=%0d required 1 0 34", i, out_valid, in_ready, sum);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL hold_result: got %h required %h", act, e);
    end
    send_run(1, 2, 3, 4, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL after_hold_result: got %h required %h", act, e);
    end
  endtask

  task automatic test_saturation();
    res_t act, e;
    send_run(225, 225, 225, 225, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL sat_result: got %h required %h", act, e);
    end
    send_run(1, 1, 1, 1, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL sat_sticky_cleared: got %h required %h", act, e);
    end
  endtask

  task automatic test_clear();
    res_t act, e;
    push_product(50);
    push_product(60);
    clear    = 1'b1;
    in_valid = 1'b1;
    product  = 8'd70;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL clear_state: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send_run(10, 10, 10, 10, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL clear_result: got %h required %h", act, e);
    end
    // A pending result is dropped by clear and must never reach the scoreboard.
    out_ready = 1'b0;
    send_run(3, 3, 3, 3, 0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, overflow} !== 3'b010) begin
      n_err++;
      $display("FAIL clear_in_done: ov=%b ir=%b ovf=%b required 0 1 0", out_valid, in_ready, overflow);
    end
    out_ready = 1'b1;
    send_run(2, 2, 2, 2, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL after_clear_done_result: got %h required %h", act, e);
    end
  endtask

  task automatic test_async_reset();
    res_t act, e;
    push_product(5);
    push_product(5);
    push_product(5);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, sum, overflow} !== {1'b0, 1'b1, 10'd0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: ov=%b ir=%b sum=%0d ovf=%b required 0 1 0 0",
               out_valid, in_ready, sum, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_run(5, 5, 5, 5, 0, 1'b1);
    get_result(act);
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL after_reset_result: got %h required %h", act, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
